char_buffer_ctrl: RTL and testbench
===================================

CHAR_BUFFER_CTRL -- requirements
Module: char_buffer_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 7, character code width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, address width in bits; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter READ_LATENCY, default 1, legal values 1 or 2; any other value SHALL fail elaboration.
REQ-004 SHALL have parameter CLEAR_VAL, default 0, DATA_W-wide value written by the clear engine.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 wr_en  input  1  direct write strobe.
REQ-008 wr_addr  input  ADDR_W  direct write address.
REQ-009 wr_data  input  DATA_W  direct write data, shared with cursor writes.
REQ-010 cur_wr  input  1  cursor write strobe: writes wr_data at the cursor address.
REQ-011 cur_set  input  1  loads the cursor from cur_addr_in.
REQ-012 cur_addr_in  input  ADDR_W  cursor load value.
REQ-013 cur_addr  output  ADDR_W  current cursor address.
REQ-014 clr_start  input  1  starts a full-buffer clear.
REQ-015 busy  output  1  high while the clear engine runs.
REQ-016 clr_done  output  1  one-cycle pulse when a clear completes.
REQ-017 wr_drop  output  1  one-cycle pulse when a requested write is discarded.
REQ-018 rd_en  input  1  read request.
REQ-019 rd_addr  input  ADDR_W  read address.
REQ-020 rd_data  output  DATA_W  read data.
REQ-021 rd_valid  output  1  qualifies rd_data.

Function
REQ-022 Storage SHALL be DEPTH x DATA_W simple dual-port RAM with one write port and one read port, both on clk.
REQ-023 FSM states SHALL be IDLE and CLEAR; IDLE->CLEAR on clr_start; CLEAR->IDLE after writing address DEPTH-1.
REQ-024 In CLEAR, the block SHALL write CLEAR_VAL to one address per cycle, ascending from 0, taking exactly DEPTH cycles.
REQ-025 busy SHALL be high in every CLEAR cycle.
REQ-026 clr_done SHALL pulse in the cycle after the DEPTH-1 write, coinciding with the return to IDLE.
REQ-027 clr_start while busy SHALL be ignored; the running clear does not restart.
REQ-028 Write priority per cycle SHALL be clear engine > wr_en > cur_wr.
REQ-029 wr_en or cur_wr while busy SHALL be discarded and pulse wr_drop the next cycle.
REQ-030 wr_en and cur_wr together in IDLE: the direct write SHALL proceed, the cursor write SHALL be discarded, the cursor SHALL not advance, and wr_drop SHALL pulse.
REQ-031 An accepted cursor write SHALL store wr_data at cur_addr and then increment cur_addr by 1, wrapping from DEPTH-1 to 0.
REQ-032 cur_set SHALL override any increment in the same cycle; cur_addr = cur_addr_in next cycle.
REQ-033 cur_set SHALL be honoured while busy.
REQ-034 A clear SHALL leave the cursor unchanged.
REQ-035 Reads SHALL operate in every state, including CLEAR.
REQ-036 rd_data and rd_valid SHALL appear READ_LATENCY cycles after rd_en: 1 = RAM output register only; 2 = extra output pipeline register.
REQ-037 rd_valid SHALL be high only in the cycles corresponding to an accepted rd_en.
REQ-038 rd_data SHALL hold its last value when rd_valid is low.
REQ-039 A read and a write to the same address in the same cycle SHALL return the old (pre-write) data.
REQ-040 Back-to-back reads SHALL sustain one result per cycle.

Reset
REQ-041 While reset is high: FSM=IDLE, busy=0, clr_done=0, wr_drop=0, cur_addr=0, rd_valid=0, rd_data=0, and the pipeline is flushed.
REQ-042 Reset asserted during CLEAR SHALL abort the clear with no clr_done pulse; addresses already cleared stay cleared and the rest are untouched.
REQ-043 RAM contents SHALL not be altered by reset.
REQ-044 Inputs sampled while reset is high SHALL have no effect.

Verification
REQ-045 Defaults; write 0x41 at addr 5; rd_en addr 5 -> rd_valid with rd_data=0x41 exactly 1 cycle later; repeat with READ_LATENCY=2 -> 2 cycles later.
REQ-046 cur_set 0xFE; three cur_wr of 0x10,0x11,0x12 -> addrs 0xFE,0xFF,0x00 hold those values; cur_addr=0x01.
REQ-047 Fill RAM with 0x7F; clr_start -> busy high for 256 cycles, clr_done one pulse; every address reads 0x00; cur_addr unchanged.
REQ-048 wr_en during CLEAR -> wr_drop pulse, write absent after clear; wr_en(addr 3, 0x22) with cur_wr same cycle -> addr 3=0x22, cur_addr unchanged, wr_drop pulse.
REQ-049 Same-cycle read and write at addr 7 (old 0x05, new 0x06) -> rd_data=0x05; next read -> 0x06.
REQ-050 Reset at clear cycle 100 -> busy=0 next cycle, no clr_done; addrs 0-99 hold CLEAR_VAL, addrs 100-255 retain prior data.

Source files
------------

// File: rtl/char_buffer_ctrl.sv
// char_buffer_ctrl: character RAM with direct/cursor writes, a full-buffer clear engine and pipelined reads
module char_buffer_ctrl #(
    parameter int                DATA_W       = 7,
    parameter int                ADDR_W       = 8,
    parameter int                READ_LATENCY = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL    = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              cur_wr,
    input  logic              cur_set,
    input  logic [ADDR_W-1:0] cur_addr_in,
    output logic [ADDR_W-1:0] cur_addr,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_drop,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);
    localparam int DEPTH = 2**ADDR_W;
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr, r_cur_addr, w_waddr;
    logic [DATA_W-1:0] w_wdata, r_rd_data1;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_clr_done, r_wr_drop, r_rd_v1;
    logic              w_busy, w_clr_last, w_we, w_drop, w_cur_acc;
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("char_buffer_ctrl: READ_LATENCY must be 1 or 2");
    end
    always_comb begin
        w_busy      = r_state == CLEAR;
        w_clr_last  = w_busy && (&r_clr_addr);
        w_state_nxt = w_busy ? (w_clr_last ? IDLE : CLEAR) : (clr_start ? CLEAR : IDLE);
        w_cur_acc   = !w_busy && cur_wr && !wr_en;
        w_drop      = w_busy ? (wr_en || cur_wr) : (wr_en && cur_wr);
        w_we        = !reset && (w_busy || wr_en || cur_wr);
        w_waddr     = w_busy ? r_clr_addr : (wr_en ? wr_addr : r_cur_addr);
        w_wdata     = w_busy ? CLEAR_VAL : wr_data;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_clr_addr <= '0;
            r_cur_addr <= '0;
            r_clr_done <= 1'b0;
            r_wr_drop  <= 1'b0;
            r_rd_v1    <= 1'b0;
            r_rd_data1 <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_busy ? r_clr_addr + ADDR_W'(1) : '0;
            r_cur_addr <= cur_set ? cur_addr_in : (w_cur_acc ? r_cur_addr + ADDR_W'(1) : r_cur_addr);
            r_clr_done <= w_clr_last;
            r_wr_drop  <= w_drop;
            r_rd_v1    <= rd_en;
            if (rd_en) r_rd_data1 <= r_mem[rd_addr];
        end
    end
    // RAM contents survive reset; reads see pre-write data on an address collision
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end
    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_W-1:0] r_rd_data2;
        logic              r_rd_v2;
        always_ff @(posedge clk) begin
            if (reset) begin
                r_rd_v2    <= 1'b0;
                r_rd_data2 <= '0;
            end else begin
                r_rd_v2 <= r_rd_v1;
                if (r_rd_v1) r_rd_data2 <= r_rd_data1;
            end
        end
        assign rd_data  = r_rd_data2;
        assign rd_valid = r_rd_v2;
    end else begin : g_lat1
        assign rd_data  = r_rd_data1;
        assign rd_valid = r_rd_v1;
    end
    assign busy     = w_busy;
    assign clr_done = r_clr_done;
    assign wr_drop  = r_wr_drop;
    assign cur_addr = r_cur_addr;
endmodule

// File: tb/tb_char_buffer_ctrl.sv
// tb_char_buffer_ctrl: random and directed stimulus against a behavioural buffer model, both read latencies
module tb_char_buffer_ctrl;
    localparam int DW = 7, AW = 8, DEPTH = 256;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic          reset, wr_en, cur_wr, cur_set, clr_start, rd_en;
    logic [AW-1:0] wr_addr, cur_addr_in, rd_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] cur_addr_a, cur_addr_b;
    logic          busy_a, busy_b, clr_done_a, clr_done_b, wr_drop_a, wr_drop_b, rd_valid_a, rd_valid_b;
    logic [DW-1:0] rd_data_a, rd_data_b;
    char_buffer_ctrl #(.READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cur_wr(cur_wr), .cur_set(cur_set), .cur_addr_in(cur_addr_in), .cur_addr(cur_addr_a),
        .clr_start(clr_start), .busy(busy_a), .clr_done(clr_done_a), .wr_drop(wr_drop_a),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a));
    char_buffer_ctrl #(.READ_LATENCY(2)) dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cur_wr(cur_wr), .cur_set(cur_set), .cur_addr_in(cur_addr_in), .cur_addr(cur_addr_b),
        .clr_start(clr_start), .busy(busy_b), .clr_done(clr_done_b), .wr_drop(wr_drop_b),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b));
    int m [DEPTH];
    int clr_idx, cur, d1, d2;
    bit e_done, e_drop, v1, v2;
    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_update();
        if (reset) begin
            clr_idx = -1; cur = 0; e_done = 0; e_drop = 0; v1 = 0; v2 = 0; d1 = 0; d2 = 0;
        end else begin
            int rv = m[rd_addr];
            int inc = 0;
            if (v1) d2 = d1;
            v2 = v1;
            if (rd_en) d1 = rv;
            v1 = rd_en;
            if (clr_idx >= 0) begin
                m[clr_idx] = 0;
                e_drop = wr_en || cur_wr;
                e_done = clr_idx == DEPTH - 1;
                clr_idx = e_done ? -1 : clr_idx + 1;
            end else begin
                e_done = 0;
                e_drop = wr_en && cur_wr;
                if (wr_en) m[wr_addr] = int'(wr_data);
                else if (cur_wr) begin
                    m[cur] = int'(wr_data);
                    inc = 1;
                end
                if (clr_start) clr_idx = 0;
            end
            cur = cur_set ? int'(cur_addr_in) : (cur + inc) % DEPTH;
        end
    endtask
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("busy_a", busy_a, clr_idx >= 0);
        chk("busy_b", busy_b, clr_idx >= 0);
        chk("clr_done_a", clr_done_a, e_done);
        chk("clr_done_b", clr_done_b, e_done);
        chk("wr_drop_a", wr_drop_a, e_drop);
        chk("wr_drop_b", wr_drop_b, e_drop);
        chk("cur_addr_a", cur_addr_a, cur);
        chk("cur_addr_b", cur_addr_b, cur);
        chk("rd_valid_l1", rd_valid_a, v1);
        chk("rd_data_l1", rd_data_a, d1);
        chk("rd_valid_l2", rd_valid_b, v2);
        chk("rd_data_l2", rd_data_b, d2);
    endtask
    task automatic idle_in();
        wr_en = 0; cur_wr = 0; cur_set = 0; clr_start = 0; rd_en = 0;
    endtask
    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 1; rd_addr = AW'(i);
            step();
        end
        idle_in();
        step(); step();
    endtask
    initial begin
        int busy_cnt, done_cnt;
        reset = 1; idle_in();
        wr_addr = '0; wr_data = '0; cur_addr_in = '0; rd_addr = '0;
        repeat (3) step();
        reset = 0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1; wr_addr = AW'(i); wr_data = 7'h7F;
            step();
        end
        idle_in();
        wr_en = 1; wr_addr = 8'd5; wr_data = 7'h41;
        step();
        idle_in(); rd_en = 1; rd_addr = 8'd5;
        step();
        chk("lat1_0x41", rd_data_a, 7'h41);
        idle_in();
        step();
        chk("lat2_0x41", rd_data_b, 7'h41);
        cur_set = 1; cur_addr_in = 8'hFE;
        step();
        idle_in();
        for (int k = 0; k < 3; k++) begin
            cur_wr = 1; wr_data = DW'(8'h10 + k);
            step();
        end
        idle_in();
        chk("cursor_wrap", cur_addr_a, 8'h01);
        for (int k = 0; k < 3; k++) begin
            rd_en = 1; rd_addr = AW'(8'hFE + k);
            step();
        end
        idle_in();
        clr_start = 1;
        step();
        idle_in();
        busy_cnt = int'(busy_a); done_cnt = 0;
        for (int i = 0; i < 270; i++) begin
            idle_in();
            if (i < 200) begin
                wr_en = ($urandom_range(7) == 0); cur_wr = ($urandom_range(7) == 0);
                clr_start = ($urandom_range(15) == 0);
                wr_addr = AW'($urandom); wr_data = DW'($urandom);
            end
            rd_en = $urandom_range(1); rd_addr = AW'($urandom);
            step();
            busy_cnt += int'(busy_a);
            done_cnt += int'(clr_done_a);
        end
        idle_in();
        chk("clear_busy_cycles", busy_cnt, 256);
        chk("clear_done_pulses", done_cnt, 1);
        chk("clear_keeps_cursor", cur_addr_a, 8'h01);
        read_all();
        wr_en = 1; wr_addr = 8'd3; wr_data = 7'h22; cur_wr = 1;
        step();
        chk("dual_write_drop", wr_drop_a, 1);
        idle_in();
        chk("dual_write_cursor", cur_addr_a, 8'h01);
        rd_en = 1; rd_addr = 8'd3;
        step();
        chk("dual_write_data", rd_data_a, 7'h22);
        idle_in();
        wr_en = 1; wr_addr = 8'd7; wr_data = 7'h05;
        step();
        rd_en = 1; rd_addr = 8'd7; wr_data = 7'h06;
        step();
        chk("rw_collision_old", rd_data_a, 7'h05);
        wr_en = 0;
        step();
        chk("rw_collision_new", rd_data_a, 7'h06);
        idle_in();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1; wr_addr = AW'(i); wr_data = DW'($urandom_range(1, 127));
            step();
        end
        idle_in();
        clr_start = 1;
        step();
        idle_in();
        repeat (100) step();
        reset = 1;
        step();
        chk("abort_busy", busy_a, 0);
        reset = 0;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            done_cnt += int'(clr_done_a);
        end
        chk("abort_no_done", done_cnt, 0);
        read_all();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(499) == 0);
            clr_start = ($urandom_range(199) == 0);
            wr_en = ($urandom_range(2) == 0); cur_wr = ($urandom_range(3) == 0);
            cur_set = ($urandom_range(15) == 0); rd_en = $urandom_range(1);
            wr_addr = AW'($urandom); wr_data = DW'($urandom);
            cur_addr_in = AW'($urandom); rd_addr = AW'($urandom);
            step();
        end
        reset = 0; idle_in();
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
